// File: rtl/mac10gbe_pkg.sv
// Shared types and constants for the 10GbE TX arbiter: FSM states, AXI beat widths, beat struct.
package mac10gbe_pkg;

   localparam int AXI_DATA_W        = 64;
   localparam int AXI_KEEP_W        = 8;
   localparam int MAX_BEATS_DEFAULT = 190;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PASS,
      ST_DROP
   } arb_state_t;

   typedef struct packed {
      logic [AXI_DATA_W-1:0] data;
      logic [AXI_KEEP_W-1:0] keep;
      logic                  last;
      logic                  user;
   } axis_beat_t;

endpackage

// File: rtl/mac10gbe_rr_pick.sv
// Round-robin winner select: first requester at or above ptr, wrapping; purely combinational.
module mac10gbe_rr_pick
   import mac10gbe_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               vld
);

   always_comb begin
      logic [IDX_W-1:0] j;
      j      = '0;
      onehot = '0;
      idx    = '0;
      vld    = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         j = IDX_W'((int'(ptr) + k) % NUM_SRC);
         if (!vld && req[j]) begin
            vld       = 1'b1;
            onehot[j] = 1'b1;
            idx       = j;
         end
      end
   end

endmodule

// File: rtl/mac10gbe_tx_arbiter.sv
// Frame-level round-robin arbiter of NUM_SRC AXI-Stream sources onto one MAC TX stream; zero-cycle
// datapath, MAC tready mirrored to the granted source; over-long frames cut at MAX_BEATS and the tail dropped.
module mac10gbe_tx_arbiter
   import mac10gbe_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int MAX_BEATS = MAX_BEATS_DEFAULT
) (
   input  logic                             mac10gbe_clk,
   input  logic                             mac_reset,
   input  logic [NUM_SRC*AXI_DATA_W-1:0]    s_tdata,
   input  logic [NUM_SRC*AXI_KEEP_W-1:0]    s_tkeep,
   input  logic [NUM_SRC-1:0]               s_tvalid,
   input  logic [NUM_SRC-1:0]               s_tlast,
   input  logic [NUM_SRC-1:0]               s_tuser,
   output logic [NUM_SRC-1:0]               s_tready,
   output logic [AXI_DATA_W-1:0]            tx_axis_mac_tdata,
   output logic [AXI_KEEP_W-1:0]            tx_axis_mac_tkeep,
   output logic                             tx_axis_mac_tvalid,
   output logic                             tx_axis_mac_tlast,
   output logic                             tx_axis_mac_tuser,
   input  logic                             tx_axis_mac_tready,
   output logic [$clog2(NUM_SRC)-1:0]       grant_idx,
   output logic                             busy,
   output logic [15:0]                      cnt_truncated
);

   localparam int IDX_W = $clog2(NUM_SRC);
   localparam int CNT_W = ($clog2(MAX_BEATS + 1) > 8) ? $clog2(MAX_BEATS + 1) : 8;

   arb_state_t         state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [NUM_SRC-1:0] grant_oh;
   logic [CNT_W-1:0]   beat_cnt;

   logic [NUM_SRC-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;

   axis_beat_t sel;
   logic       sel_vld;
   logic       accept;
   logic       at_limit;
   logic       trunc;

   mac10gbe_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (s_tvalid),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .vld    (pick_vld)
   );

   always_comb begin
      sel.data = s_tdata[grant_idx*AXI_DATA_W +: AXI_DATA_W];
      sel.keep = s_tkeep[grant_idx*AXI_KEEP_W +: AXI_KEEP_W];
      sel.last = s_tlast[grant_idx];
      sel.user = s_tuser[grant_idx];
      sel_vld  = s_tvalid[grant_idx];
   end

   // beat_cnt holds beats already accepted, so the current beat is number beat_cnt+1
   assign at_limit = (beat_cnt == CNT_W'(MAX_BEATS - 1));
   assign trunc    = at_limit && !sel.last;
   assign accept   = (state == ST_PASS) && sel_vld && tx_axis_mac_tready;
   assign busy     = (state != ST_IDLE);

   always_comb begin
      tx_axis_mac_tdata  = '0;
      tx_axis_mac_tkeep  = '0;
      tx_axis_mac_tvalid = 1'b0;
      tx_axis_mac_tlast  = 1'b0;
      tx_axis_mac_tuser  = 1'b0;
      s_tready           = '0;
      case (state)
         ST_PASS: begin
            tx_axis_mac_tdata  = sel.data;
            tx_axis_mac_tkeep  = sel.keep;
            tx_axis_mac_tvalid = sel_vld;
            tx_axis_mac_tlast  = sel.last | at_limit;
            tx_axis_mac_tuser  = sel.user | trunc;
            s_tready           = grant_oh & {NUM_SRC{tx_axis_mac_tready}};
         end
         ST_DROP: s_tready = grant_oh;
         default: ;
      endcase
   end

   always_ff @(posedge mac10gbe_clk or posedge mac_reset) begin
      if (mac_reset) begin
         state         <= ST_IDLE;
         grant_idx     <= '0;
         grant_oh      <= '0;
         rr_ptr        <= '0;
         beat_cnt      <= '0;
         cnt_truncated <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_vld) begin
                  state     <= ST_PASS;
                  grant_idx <= pick_idx;
                  grant_oh  <= pick_oh;
                  beat_cnt  <= '0;
                  rr_ptr    <= (pick_idx == IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + IDX_W'(1);
               end
            end
            ST_PASS: begin
               if (accept) begin
                  if (sel.last) begin
                     state <= ST_IDLE;
                  end else if (at_limit) begin
                     state <= ST_DROP;
                     if (cnt_truncated != 16'hFFFF) cnt_truncated <= cnt_truncated + 16'd1;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            ST_DROP: begin
               if (sel_vld && sel.last) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac10gbe_tx_arbiter.sv
// Bench for mac10gbe_tx_arbiter: directed scenarios plus random frames against a frame-level model.
module tb_mac10gbe_tx_arbiter;

   localparam int N    = 4;
   localparam int MAXB = 190;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   logic            clk = 1'b0;
   logic            mac_reset;
   logic [N*64-1:0] s_tdata;
   logic [N*8-1:0]  s_tkeep;
   logic [N-1:0]    s_tvalid;
   logic [N-1:0]    s_tlast;
   logic [N-1:0]    s_tuser;
   logic [N-1:0]    s_tready;
   logic [63:0]     tx_axis_mac_tdata;
   logic [7:0]      tx_axis_mac_tkeep;
   logic            tx_axis_mac_tvalid;
   logic            tx_axis_mac_tlast;
   logic            tx_axis_mac_tuser;
   logic            tx_axis_mac_tready;
   logic [1:0]      grant_idx;
   logic            busy;
   logic [15:0]     cnt_truncated;

   always #5 clk = ~clk;

   mac10gbe_tx_arbiter #(.NUM_SRC(N), .MAX_BEATS(MAXB)) dut (
      .mac10gbe_clk       (clk),
      .mac_reset          (mac_reset),
      .s_tdata            (s_tdata),
      .s_tkeep            (s_tkeep),
      .s_tvalid           (s_tvalid),
      .s_tlast            (s_tlast),
      .s_tuser            (s_tuser),
      .s_tready           (s_tready),
      .tx_axis_mac_tdata  (tx_axis_mac_tdata),
      .tx_axis_mac_tkeep  (tx_axis_mac_tkeep),
      .tx_axis_mac_tvalid (tx_axis_mac_tvalid),
      .tx_axis_mac_tlast  (tx_axis_mac_tlast),
      .tx_axis_mac_tuser  (tx_axis_mac_tuser),
      .tx_axis_mac_tready (tx_axis_mac_tready),
      .grant_idx          (grant_idx),
      .busy               (busy),
      .cnt_truncated      (cnt_truncated)
   );

   beat_t srcq[N][$];
   beat_t exp_out[$];
   int    exp_grant[$];
   bit    tr_pat[$];
   int    rdy_pct = 100;
   int    mptr = 0;
   int    mtrunc = 0;
   int    checks = 0;
   int    failures = 0;
   bit    expect_idle = 0;
   bit    dropping = 0;
   bit    prev_busy = 0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add_frame(input int src, input int len, input bit rand_user);
      beat_t b;
      for (int k = 1; k <= len; k++) begin
         b.data = {$urandom, $urandom};
         b.last = (k == len);
         b.keep = b.last ? 8'($urandom_range(1, 255)) : 8'hFF;
         b.user = rand_user && ($urandom_range(0, 7) == 0);
         srcq[src].push_back(b);
      end
   endtask

   // Frame-level model: round-robin over sources holding frames, cut at MAXB beats.
   task automatic model_build();
      beat_t mq[N][$];
      beat_t b;
      int    s;
      int    n;
      bit    src_last;
      for (int i = 0; i < N; i++) mq[i] = srcq[i];
      while (1) begin
         s = -1;
         for (int k = 0; k < N; k++)
            if (s < 0 && mq[(mptr + k) % N].size() != 0) s = (mptr + k) % N;
         if (s < 0) break;
         exp_grant.push_back(s);
         mptr = (s + 1) % N;
         n = 0;
         src_last = 0;
         while (!src_last) begin
            b = mq[s].pop_front();
            n++;
            src_last = b.last;
            if (n == MAXB && !b.last) begin
               b.last = 1'b1;
               b.user = 1'b1;
               if (mtrunc < 65535) mtrunc++;
            end
            if (n <= MAXB) exp_out.push_back(b);
         end
      end
   endtask

   task automatic run(input int budget, input int stop_beats);
      int          cyc = 0;
      int          acc = 0;
      int          pend;
      int          eg;
      bit          done = 0;
      bit          trunc_now;
      beat_t       b;
      beat_t       e;
      logic [N-1:0] want;
      while (!done) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            b = '0;
            if (srcq[i].size() != 0) b = srcq[i][0];
            s_tvalid[i]          = (srcq[i].size() != 0);
            s_tdata[i*64 +: 64]  = b.data;
            s_tkeep[i*8 +: 8]    = b.keep;
            s_tlast[i]           = b.last;
            s_tuser[i]           = b.user;
         end
         if (tr_pat.size() != 0) tx_axis_mac_tready = tr_pat.pop_front();
         else tx_axis_mac_tready = ($urandom_range(1, 100) <= rdy_pct);
         #1;
         if (expect_idle) begin
            check("idle_bubble", busy, 1'b0);
            expect_idle = 0;
         end
         if (busy && !prev_busy) begin
            eg = -1;
            if (exp_grant.size() != 0) eg = exp_grant.pop_front();
            check("grant_idx", grant_idx, eg);
         end
         prev_busy = busy;
         want = '0;
         if (busy) want[grant_idx] = dropping ? 1'b1 : tx_axis_mac_tready;
         check("s_tready", s_tready, want);
         check("tx_tvalid", tx_axis_mac_tvalid, busy && !dropping && s_tvalid[grant_idx]);
         trunc_now = 0;
         if (tx_axis_mac_tvalid && tx_axis_mac_tready) begin
            if (exp_out.size() == 0) begin
               check("unexpected_out_beat", tx_axis_mac_tvalid, 1'b0);
            end else begin
               e = exp_out.pop_front();
               check("out_beat", {tx_axis_mac_tdata, tx_axis_mac_tkeep,
                                  tx_axis_mac_tlast, tx_axis_mac_tuser}, e);
               trunc_now = e.last;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
               b = srcq[i].pop_front();
               acc++;
               if (b.last) begin
                  expect_idle = 1;
                  dropping    = 0;
               end else if (trunc_now) begin
                  dropping = 1;
               end
            end
         end
         cyc++;
         pend = exp_out.size();
         for (int i = 0; i < N; i++) pend += srcq[i].size();
         if (stop_beats != 0 && acc >= stop_beats) done = 1;
         else if (pend == 0 && !busy && !expect_idle) done = 1;
         else if (cyc >= budget) begin
            check("timeout_pending_beats", pend, 0);
            check("timeout_busy", busy, 1'b0);
            done = 1;
         end
      end
   endtask

   task automatic end_checks();
      check("grants_left", exp_grant.size(), 0);
      check("cnt_truncated", cnt_truncated, mtrunc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      mac_reset = 1'b1;
      #1;
      check("rst_tvalid", tx_axis_mac_tvalid, 1'b0);
      check("rst_tlast", tx_axis_mac_tlast, 1'b0);
      check("rst_tuser", tx_axis_mac_tuser, 1'b0);
      check("rst_tdata", tx_axis_mac_tdata, 64'h0);
      check("rst_tkeep", tx_axis_mac_tkeep, 8'h0);
      check("rst_s_tready", s_tready, 4'h0);
      check("rst_grant_idx", grant_idx, 2'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_cnt_truncated", cnt_truncated, 16'h0);
      for (int i = 0; i < N; i++) srcq[i].delete();
      exp_out.delete();
      exp_grant.delete();
      tr_pat.delete();
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      s_tuser  = '0;
      tx_axis_mac_tready = 1'b0;
      mptr = 0;
      mtrunc = 0;
      expect_idle = 0;
      dropping = 0;
      prev_busy = 0;
      @(negedge clk);
      @(negedge clk);
      mac_reset = 1'b0;
   endtask

   initial begin
      int nf;
      int len;
      mac_reset = 1'b1;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      s_tuser  = '0;
      tx_axis_mac_tready = 1'b0;
      do_reset();

      // src0 and src2 contend from reset: 0 then 2
      rdy_pct = 100;
      add_frame(0, 5, 0);
      add_frame(2, 5, 0);
      model_build();
      run(200, 0);
      end_checks();

      // all four requesting 3-beat frames: 0,1,2,3,0
      do_reset();
      add_frame(0, 3, 0);
      add_frame(0, 3, 0);
      add_frame(1, 3, 0);
      add_frame(2, 3, 0);
      add_frame(3, 3, 0);
      model_build();
      run(300, 0);
      end_checks();

      // MAC backpressure 1,0,0,1 mid-frame
      do_reset();
      add_frame(0, 6, 0);
      tr_pat = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      model_build();
      run(200, 0);
      end_checks();

      // 200-beat frame truncated at 190, then src2 proceeds
      add_frame(1, 200, 0);
      add_frame(2, 4, 0);
      model_build();
      run(2000, 0);
      end_checks();

      // exactly 190 beats with tlast on 190: normal frame
      rdy_pct = 80;
      add_frame(3, 190, 0);
      model_build();
      run(2000, 0);
      end_checks();

      // reset mid-frame on src2, then src3 and src0 contend: pointer back at 0
      rdy_pct = 100;
      add_frame(2, 6, 0);
      model_build();
      run(100, 2);
      do_reset();
      add_frame(3, 2, 0);
      add_frame(0, 2, 0);
      model_build();
      run(200, 0);
      end_checks();

      for (int r = 0; r < 8; r++) begin
         if (r % 3 == 0) do_reset();
         for (int i = 0; i < N; i++) begin
            nf = $urandom_range(0, 2);
            for (int f = 0; f < nf; f++) begin
               if ($urandom_range(0, 9) == 0) len = $urandom_range(186, 194);
               else len = $urandom_range(1, 10);
               add_frame(i, len, 1);
            end
         end
         rdy_pct = $urandom_range(40, 100);
         model_build();
         run(8000, 0);
         end_checks();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac10gbe_tx_arbiter.md
MAC10GBE_TX_ARBITER -- requirements
Module: mac10gbe_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of AXI-Stream TX requesters (2..8).
REQ-002 SHALL have parameter MAX_BEATS, default 190, maximum 64-bit beats per frame before truncation.
REQ-003 SHALL have port mac10gbe_clk  input  1  single clock for all logic.
REQ-004 SHALL have port mac_reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports s_tdata/s_tkeep  input  NUM_SRC*64 / NUM_SRC*8  per-source data/byte enables, source i at slice i.
REQ-006 SHALL have ports s_tvalid/s_tlast/s_tuser  input  NUM_SRC each  per-source valid, end-of-frame, error flag.
REQ-007 SHALL have port s_tready  output  NUM_SRC  per-source ready.
REQ-008 SHALL have ports tx_axis_mac_tdata/tkeep/tvalid/tlast/tuser  output  64/8/1/1/1  stream to MAC TX.
REQ-009 SHALL have port tx_axis_mac_tready  input  1  MAC TX ready.
REQ-010 SHALL have port grant_idx  output  clog2(NUM_SRC)  currently/last granted source.
REQ-011 SHALL have port busy  output  1  high in PASS or DROP.
REQ-012 SHALL have port cnt_truncated  output  16  frames truncated for exceeding MAX_BEATS, saturating.

Function
REQ-013 SHALL implement FSM states IDLE, PASS, DROP.
- IDLE: if any s_tvalid high, register grant to winner, go PASS next cycle; all s_tready low, tx_axis_mac_tvalid low.
REQ-014 SHALL select winner round-robin: first requesting source searching from (last grant + 1) mod NUM_SRC upward; after reset search starts at 0.
REQ-015 SHALL, in PASS, combinationally route granted source to tx_axis_mac_* and tx_axis_mac_tready to s_tready[grant]; zero-cycle datapath latency; non-granted s_tready low.
REQ-016 SHALL count accepted beats (tvalid & tready) in PASS in an 8-bit-minimum counter cleared on entry to PASS.
REQ-017 SHALL, on accepted beat with s_tlast high, return to IDLE next cycle; arbitration for the next frame occurs in IDLE (one idle bubble between frames).
REQ-018 SHALL, when accepted beat number MAX_BEATS has s_tlast low, drive tx_axis_mac_tlast=1 and tx_axis_mac_tuser=1 on that beat, increment cnt_truncated, go DROP.
REQ-019 SHALL, if beat MAX_BEATS carries s_tlast high, treat the frame as normal (no truncation, no count).
REQ-020 SHALL, in DROP, hold s_tready[grant]=1, tx_axis_mac_tvalid=0, discard beats until an accepted s_tlast, then go IDLE.
REQ-021 SHALL pass s_tuser unchanged in PASS, OR'd with truncation flag on the forced last beat.
REQ-022 SHALL never change grant while in PASS or DROP, regardless of other requests.
REQ-023 SHALL hold cnt_truncated at 16'hFFFF once saturated.

Reset
REQ-024 SHALL, while mac_reset high: state IDLE, grant_idx 0, RR pointer 0, beat counter 0, cnt_truncated 0, all s_tready 0, tx_axis_mac_tvalid/tlast/tuser 0, tdata/tkeep 0, busy 0.
REQ-025 SHALL, on reset asserted mid-frame, abandon the frame without emitting tlast; source-side recovery is out of scope.

Structure
REQ-026 SHALL place state enum, AXI beat width constants (64/8) and MAX_BEATS default in shared package mac10gbe_pkg.
REQ-027 SHALL implement winner selection in sub-module mac10gbe_rr_pick (request vector + pointer in, one-hot/index + valid out, purely combinational).

Verification
REQ-028 SHALL cover: src0 and src2 both request 5-beat frames from reset -> src0 frame fully output, then src2, grant_idx 0 then 2.
REQ-029 SHALL cover: all 4 sources continuously requesting 3-beat frames -> grant order 0,1,2,3,0, one idle cycle between frames.
REQ-030 SHALL cover: tx_axis_mac_tready toggled 1,0,0,1 mid-frame -> s_tready[grant] mirrors it, no beat lost or duplicated.
REQ-031 SHALL cover: src1 sends 200-beat frame, MAX_BEATS=190 -> beat 190 output with tlast=1,tuser=1, beats 191..200 dropped, cnt_truncated=1, next grant proceeds.
REQ-032 SHALL cover: src3 sends exactly 190 beats with tlast on 190 -> normal frame, tuser=0, cnt_truncated unchanged.
REQ-033 SHALL cover: mac_reset pulsed on beat 3 of a frame -> all outputs 0 same cycle, grant_idx 0, next request arbitrated from source 0.
